// File: rtl/cnn_pkg.sv
// Shared definitions for the cnn run controller: default geometry, word width
// and the run-sequencer state encoding.
package cnn_pkg;

  localparam int DEF_DATA_W    = 16;       // Q8.8 fixed point
  localparam int DEF_IN_DEPTH  = 4096;     // 64*64*1 input words
  localparam int DEF_OUT_DEPTH = 30720;    // 32*32*30 result words
  localparam int DEF_TIMEOUT   = 1000000;  // cycles from start to core_done

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FEED  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } run_state_e;

endpackage

// File: rtl/cnn_prefetch_fifo.sv
// Two-entry FIFO that absorbs the one-cycle image RAM read latency so the
// core stream can run at one word per cycle and survive arbitrary stalls.
module cnn_prefetch_fifo #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_empty,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_do_push = i_push && (r_count != 2'd2) && !i_flush;
  assign w_do_pop  = i_pop && (r_count != 2'd0) && !i_flush;

  // NOTE: the storage array has no reset; r_count alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/cnn_run_ctrl.sv
// Sequences one cnn inference: streams the image RAM into the core, captures
// core results into the result RAM, and reports status and counts to the host.
module cnn_run_ctrl
  import cnn_pkg::*;
#(
  parameter int  IN_DEPTH  = DEF_IN_DEPTH,
  parameter int  OUT_DEPTH = DEF_OUT_DEPTH,
  parameter int  DATA_W    = DEF_DATA_W,
  parameter int  TIMEOUT   = DEF_TIMEOUT,
  localparam int RA_W      = $clog2(IN_DEPTH),
  localparam int OA_W      = $clog2(OUT_DEPTH),
  localparam int OC_W      = $clog2(OUT_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       cycle_count,
  output logic [OC_W-1:0]   out_count,
  output logic              img_rd_en,
  output logic [RA_W-1:0]   img_rd_addr,
  input  logic [DATA_W-1:0] img_rd_data,
  output logic              core_enable,
  output logic              core_in_valid,
  input  logic              core_in_ready,
  output logic [DATA_W-1:0] core_in_data,
  input  logic              core_out_valid,
  // one bit wider than a result index when OUT_DEPTH is a power of two, so bad indices are visible
  input  logic [OC_W-1:0]   core_out_addr,
  input  logic [DATA_W-1:0] core_out_data,
  input  logic              core_done,
  output logic              res_wr_en,
  output logic [OA_W-1:0]   res_wr_addr,
  output logic [DATA_W-1:0] res_wr_data
);

  run_state_e        r_state, w_state_nxt;
  logic [31:0]       r_cycle_count;
  logic [OC_W-1:0]   r_out_count;
  logic [RA_W:0]     r_issued, r_popped;
  logic              r_rd_pending, r_done, r_error;
  logic              r_res_wr_en;
  logic [OA_W-1:0]   r_res_wr_addr;
  logic [DATA_W-1:0] r_res_wr_data;

  logic              w_feed, w_busy, w_start_acc, w_timeout;
  logic              w_pop, w_last_pop, w_rd_en, w_push, w_flush;
  logic              w_bad_addr, w_res_acc, w_fifo_empty;
  logic [1:0]        w_fifo_count;
  logic [DATA_W-1:0] w_fifo_data;

  assign w_feed      = (r_state == ST_FEED);
  assign w_busy      = w_feed || (r_state == ST_DRAIN);
  assign w_start_acc = start && !abort && (r_state inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign w_timeout   = w_busy && (r_cycle_count == 32'(TIMEOUT - 1));
  assign w_pop       = w_feed && !w_fifo_empty && core_in_ready;
  assign w_last_pop  = w_pop && (r_popped == (RA_W + 1)'(IN_DEPTH - 1));
  // a pop this cycle frees a slot in time for the read issued now
  assign w_rd_en     = w_feed && (r_issued < (RA_W + 1)'(IN_DEPTH)) &&
                       (((w_fifo_count + {1'b0, r_rd_pending}) < 2'd2) || w_pop);
  assign w_push      = w_feed && r_rd_pending;
  assign w_flush     = abort || w_start_acc;
  assign w_bad_addr  = (core_out_addr >= OC_W'(OUT_DEPTH));
  assign w_res_acc   = w_busy && core_out_valid && !w_bad_addr;

  cnn_prefetch_fifo #(.W(DATA_W)) u_prefetch (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  (img_rd_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // NOTE: the next state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) w_state_nxt = ST_FEED;
      ST_FEED: begin
        if (w_timeout)       w_state_nxt = ST_ERROR;
        else if (core_done)  w_state_nxt = w_last_pop ? ST_DONE : ST_ERROR;
        else if (w_last_pop) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_timeout)      w_state_nxt = ST_ERROR;
        else if (core_done) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (abort) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cycle_count <= '0;
      r_out_count   <= '0;
      r_issued      <= '0;
      r_popped      <= '0;
      r_rd_pending  <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_res_wr_en   <= 1'b0;
      r_res_wr_addr <= '0;
      r_res_wr_data <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_done       <= (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
      r_rd_pending <= w_rd_en && !abort;
      r_res_wr_en  <= w_res_acc;
      if (w_res_acc) begin
        r_res_wr_addr <= core_out_addr[OA_W-1:0];
        r_res_wr_data <= core_out_data;
      end
      if (w_start_acc) begin
        r_cycle_count <= '0;
        r_out_count   <= '0;
        r_issued      <= '0;
        r_popped      <= '0;
        r_error       <= 1'b0;
      end else begin
        if (w_busy && !abort && !w_timeout) r_cycle_count <= r_cycle_count + 32'd1;
        if (w_res_acc) r_out_count <= r_out_count + 1'b1;
        if (w_rd_en)   r_issued    <= r_issued + 1'b1;
        if (w_pop)     r_popped    <= r_popped + 1'b1;
        if ((w_busy && core_out_valid && w_bad_addr) ||
            ((w_state_nxt == ST_ERROR) && (r_state != ST_ERROR)))
          r_error <= 1'b1;
      end
    end
  end

  assign busy          = w_busy;
  assign core_enable   = w_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign cycle_count   = r_cycle_count;
  assign out_count     = r_out_count;
  assign img_rd_en     = w_rd_en;
  assign img_rd_addr   = r_issued[RA_W-1:0];
  assign core_in_valid = w_feed && !w_fifo_empty;
  assign core_in_data  = core_in_valid ? w_fifo_data : '0;
  assign res_wr_en     = r_res_wr_en;
  assign res_wr_addr   = r_res_wr_addr;
  assign res_wr_data   = r_res_wr_data;

endmodule

// File: tb/tb_cnn_run_ctrl.sv
// Directed bench for cnn_run_ctrl: small image/result geometry, a synchronous
// image RAM model, and stream/write monitors feeding hand-computed expectations.
module tb_cnn_run_ctrl;

  localparam int IN_DEPTH  = 16;
  localparam int OUT_DEPTH = 8;
  localparam int DATA_W    = 16;
  localparam int RA_W      = 4;
  localparam int OA_W      = 3;
  localparam int OC_W      = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              start = 1'b0, abort = 1'b0;
  logic              busy, done, error, img_rd_en, core_enable, core_in_valid, res_wr_en;
  logic [31:0]       cycle_count;
  logic [OC_W-1:0]   out_count;
  logic [RA_W-1:0]   img_rd_addr;
  logic [DATA_W-1:0] img_rd_data = '0;
  logic              core_in_ready = 1'b1;
  logic [DATA_W-1:0] core_in_data;
  logic              core_out_valid = 1'b0;
  logic [OC_W-1:0]   core_out_addr = '0;
  logic [DATA_W-1:0] core_out_data = '0;
  logic              core_done = 1'b0;
  logic [OA_W-1:0]   res_wr_addr;
  logic [DATA_W-1:0] res_wr_data;

  cnn_run_ctrl #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH), .DATA_W(DATA_W), .TIMEOUT(200)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .error(error), .cycle_count(cycle_count), .out_count(out_count),
    .img_rd_en(img_rd_en), .img_rd_addr(img_rd_addr), .img_rd_data(img_rd_data),
    .core_enable(core_enable), .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
    .core_in_data(core_in_data), .core_out_valid(core_out_valid), .core_out_addr(core_out_addr),
    .core_out_data(core_out_data), .core_done(core_done),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data)
  );

  // second instance with a short timeout and a core that never finishes
  logic              t_start = 1'b0, t_abort = 1'b0;
  logic              t_busy, t_done, t_error, t_img_rd_en, t_core_enable, t_core_in_valid, t_res_wr_en;
  logic [31:0]       t_cycle_count;
  logic [OC_W-1:0]   t_out_count;
  logic [RA_W-1:0]   t_img_rd_addr;
  logic [DATA_W-1:0] t_img_rd_data = '0;
  logic              t_core_in_ready = 1'b1;
  logic [DATA_W-1:0] t_core_in_data;
  logic              t_core_out_valid = 1'b0;
  logic [OC_W-1:0]   t_core_out_addr = '0;
  logic [DATA_W-1:0] t_core_out_data = '0;
  logic              t_core_done = 1'b0;
  logic [OA_W-1:0]   t_res_wr_addr;
  logic [DATA_W-1:0] t_res_wr_data;

  cnn_run_ctrl #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH), .DATA_W(DATA_W), .TIMEOUT(50)) dut_to (
    .clk(clk), .reset(reset), .start(t_start), .abort(t_abort),
    .busy(t_busy), .done(t_done), .error(t_error), .cycle_count(t_cycle_count), .out_count(t_out_count),
    .img_rd_en(t_img_rd_en), .img_rd_addr(t_img_rd_addr), .img_rd_data(t_img_rd_data),
    .core_enable(t_core_enable), .core_in_valid(t_core_in_valid), .core_in_ready(t_core_in_ready),
    .core_in_data(t_core_in_data), .core_out_valid(t_core_out_valid), .core_out_addr(t_core_out_addr),
    .core_out_data(t_core_out_data), .core_done(t_core_done),
    .res_wr_en(t_res_wr_en), .res_wr_addr(t_res_wr_addr), .res_wr_data(t_res_wr_data)
  );

  // image RAMs hold word == address, one cycle read latency
  always @(posedge clk) begin
    if (img_rd_en)   img_rd_data   <= DATA_W'(img_rd_addr);
    if (t_img_rd_en) t_img_rd_data <= DATA_W'(t_img_rd_addr);
  end

  logic [DATA_W-1:0]      rx_q[$];
  logic [OA_W+DATA_W-1:0] wr_q[$];
  int rd_cnt = 0, done_cnt = 0;
  always @(posedge clk) begin
    if (core_in_valid && core_in_ready) rx_q.push_back(core_in_data);
    if (res_wr_en) wr_q.push_back({res_wr_addr, res_wr_data});
    if (img_rd_en) rd_cnt++;
    if (done) done_cnt++;
  end

  int checks = 0, errors = 0;

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic start_run;
    start = 1'b1; step; start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; repeat (3) step;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b exp 0", error); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cycle: got %0d exp 0", cycle_count); end
    checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL reset_outcnt: got %0d exp 0", out_count); end
    checks++; if ({img_rd_en, core_enable, core_in_valid, res_wr_en} !== 4'b0) begin errors++;
      $display("FAIL reset_strobes: got %b exp 0000", {img_rd_en, core_enable, core_in_valid, res_wr_en}); end
    reset = 1'b0; step;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b exp 0", busy); end
  endtask

  task automatic test_stream;
    int waits;
    logic [OA_W+DATA_W-1:0] exp_w;
    rx_q.delete(); wr_q.delete(); rd_cnt = 0; done_cnt = 0; core_in_ready = 1'b1;
    start_run;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stream_busy: got %b exp 1", busy); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL stream_cyc0: got %0d exp 0", cycle_count); end
    waits = 0;
    while (!core_in_valid && waits < 10) begin step; waits++; end
    checks++; if (waits !== 2) begin errors++; $display("FAIL stream_latency: got %0d exp 2", waits); end
    for (int i = 0; i < IN_DEPTH; i++) begin
      checks++; if (core_in_valid !== 1'b1 || core_in_data !== 16'(i)) begin errors++;
        $display("FAIL stream_word%0d: got v=%b d=%0d exp v=1 d=%0d", i, core_in_valid, core_in_data, i); end
      step;
    end
    checks++; if (busy !== 1'b1 || core_in_valid !== 1'b0) begin errors++;
      $display("FAIL stream_drain: got busy=%b valid=%b exp 1 0", busy, core_in_valid); end
    checks++; if (rd_cnt !== IN_DEPTH) begin errors++; $display("FAIL stream_reads: got %0d exp 16", rd_cnt); end
    for (int i = 0; i < OUT_DEPTH; i++) begin
      core_out_valid = 1'b1; core_out_addr = 4'(i); core_out_data = 16'(256 + i);
      core_done = (i == OUT_DEPTH - 1);
      step;
    end
    core_out_valid = 1'b0; core_done = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stream_done: got %b exp 1", done); end
    checks++; if (busy !== 1'b0 || core_enable !== 1'b0) begin errors++;
      $display("FAIL stream_busy_end: got busy=%b en=%b exp 0 0", busy, core_enable); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL stream_error: got %b exp 0", error); end
    checks++; if (cycle_count !== 32'd26) begin errors++; $display("FAIL stream_cycles: got %0d exp 26", cycle_count); end
    checks++; if (out_count !== 4'd8) begin errors++; $display("FAIL stream_outcnt: got %0d exp 8", out_count); end
    step;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stream_done_pulse: got %b exp 0", done); end
    checks++; if (cycle_count !== 32'd26) begin errors++; $display("FAIL stream_cyc_frozen: got %0d exp 26", cycle_count); end
    checks++; if (wr_q.size() !== OUT_DEPTH) begin errors++; $display("FAIL stream_nwrites: got %0d exp 8", wr_q.size()); end
    for (int i = 0; i < OUT_DEPTH && i < wr_q.size(); i++) begin
      exp_w = {3'(i), 16'(256 + i)};
      checks++; if (wr_q[i] !== exp_w) begin errors++; $display("FAIL stream_write%0d: got %h exp %h", i, wr_q[i], exp_w); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL stream_done_count: got %0d exp 1", done_cnt); end
  endtask

  task automatic test_stalls;
    int cyc;
    rx_q.delete(); rd_cnt = 0;
    start_run;
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL stall_restart_cyc: got %0d exp 0", cycle_count); end
    cyc = 0;
    while (rx_q.size() < IN_DEPTH && cyc < 400) begin
      core_in_ready = (cyc < 24) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      step; cyc++;
    end
    core_in_ready = 1'b1;
    checks++; if (rx_q.size() !== IN_DEPTH) begin errors++; $display("FAIL stall_count: got %0d exp 16", rx_q.size()); end
    for (int i = 0; i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== 16'(i)) begin errors++; $display("FAIL stall_word%0d: got %0d exp %0d", i, rx_q[i], i); end
    end
    repeat (2) step;
    checks++; if (busy !== 1'b1 || core_in_valid !== 1'b0) begin errors++;
      $display("FAIL stall_drain: got busy=%b valid=%b exp 1 0", busy, core_in_valid); end
    checks++; if (rd_cnt !== IN_DEPTH) begin errors++; $display("FAIL stall_reads: got %0d exp 16", rd_cnt); end
    core_done = 1'b1; step; core_done = 1'b0;
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++;
      $display("FAIL stall_done: got done=%b err=%b exp 1 0", done, error); end
  endtask

  task automatic test_early_done;
    int cyc;
    rx_q.delete(); core_in_ready = 1'b1;
    start_run;
    cyc = 0;
    while (rx_q.size() < 10 && cyc < 100) begin step; cyc++; end
    core_in_ready = 1'b0; core_done = 1'b1; step; core_done = 1'b0; core_in_ready = 1'b1;
    checks++; if (rx_q.size() !== 10) begin errors++; $display("FAIL early_words: got %0d exp 10", rx_q.size()); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL early_error: got %b exp 1", error); end
    checks++; if (busy !== 1'b0 || core_enable !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL early_state: got busy=%b en=%b done=%b exp 0 0 0", busy, core_enable, done); end
    step;
    checks++; if (img_rd_en !== 1'b0 || core_in_valid !== 1'b0 || error !== 1'b1) begin errors++;
      $display("FAIL early_quiet: got rd=%b v=%b err=%b exp 0 0 1", img_rd_en, core_in_valid, error); end
    rx_q.delete();
    start_run;
    checks++; if (error !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL early_restart: got err=%b busy=%b exp 0 1", error, busy); end
    cyc = 0;
    while (rx_q.size() < IN_DEPTH && cyc < 100) begin step; cyc++; end
    checks++; if (rx_q.size() !== IN_DEPTH || rx_q[0] !== 16'd0 || rx_q[IN_DEPTH-1] !== 16'd15) begin errors++;
      $display("FAIL early_rerun_stream: got n=%0d", rx_q.size()); end
    core_done = 1'b1; step; core_done = 1'b0;
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++;
      $display("FAIL early_rerun_done: got done=%b err=%b exp 1 0", done, error); end
  endtask

  task automatic test_timeout;
    int waits;
    t_start = 1'b1; step; t_start = 1'b0;
    waits = 0;
    while (!t_error && waits < 200) begin step; waits++; end
    checks++; if (waits !== 50) begin errors++; $display("FAIL to_latency: got %0d exp 50", waits); end
    checks++; if (t_cycle_count !== 32'd49) begin errors++; $display("FAIL to_cycle: got %0d exp 49", t_cycle_count); end
    checks++; if (t_core_enable !== 1'b0 || t_busy !== 1'b0) begin errors++;
      $display("FAIL to_enable: got en=%b busy=%b exp 0 0", t_core_enable, t_busy); end
    step;
    checks++; if (t_cycle_count !== 32'd49 || t_error !== 1'b1) begin errors++;
      $display("FAIL to_frozen: got cyc=%0d err=%b exp 49 1", t_cycle_count, t_error); end
  endtask

  task automatic test_bad_addr_abort;
    logic [OA_W+DATA_W-1:0] exp_w;
    wr_q.delete(); done_cnt = 0; core_in_ready = 1'b1;
    start_run;
    core_out_valid = 1'b1; core_out_addr = 4'd0; core_out_data = 16'h00A1; step;
    core_out_addr = 4'd9; core_out_data = 16'h00B2; step;
    core_out_addr = 4'd1; core_out_data = 16'h00C3; step;
    core_out_valid = 1'b0;
    checks++; if (error !== 1'b1 || busy !== 1'b1) begin errors++;
      $display("FAIL badaddr_err: got err=%b busy=%b exp 1 1", error, busy); end
    checks++; if (out_count !== 4'd2) begin errors++; $display("FAIL badaddr_outcnt: got %0d exp 2", out_count); end
    step;
    checks++; if (wr_q.size() !== 2) begin errors++; $display("FAIL badaddr_nwrites: got %0d exp 2", wr_q.size()); end
    if (wr_q.size() == 2) begin
      exp_w = {3'd0, 16'h00A1};
      checks++; if (wr_q[0] !== exp_w) begin errors++; $display("FAIL badaddr_w0: got %h exp %h", wr_q[0], exp_w); end
      exp_w = {3'd1, 16'h00C3};
      checks++; if (wr_q[1] !== exp_w) begin errors++; $display("FAIL badaddr_w1: got %h exp %h", wr_q[1], exp_w); end
    end
    abort = 1'b1; step; abort = 1'b0;
    checks++; if (busy !== 1'b0 || core_enable !== 1'b0) begin errors++;
      $display("FAIL abort_idle: got busy=%b en=%b exp 0 0", busy, core_enable); end
    checks++; if (out_count !== 4'd2 || error !== 1'b1) begin errors++;
      $display("FAIL abort_hold: got cnt=%0d err=%b exp 2 1", out_count, error); end
    step;
    checks++; if (done_cnt !== 0 || img_rd_en !== 1'b0 || core_in_valid !== 1'b0) begin errors++;
      $display("FAIL abort_quiet: got dones=%0d rd=%b v=%b exp 0 0 0", done_cnt, img_rd_en, core_in_valid); end
  endtask

  task automatic test_start_in_drain;
    core_in_ready = 1'b1;
    start_run;
    repeat (18) step;
    checks++; if (busy !== 1'b1 || core_in_valid !== 1'b0 || cycle_count !== 32'd18) begin errors++;
      $display("FAIL drain_entry: got busy=%b v=%b cyc=%0d exp 1 0 18", busy, core_in_valid, cycle_count); end
    start = 1'b1; step; start = 1'b0;
    checks++; if (cycle_count !== 32'd19 || busy !== 1'b1 || core_in_valid !== 1'b0) begin errors++;
      $display("FAIL drain_start_ignored: got cyc=%0d busy=%b v=%b exp 19 1 0", cycle_count, busy, core_in_valid); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL drain_error: got %b exp 0", error); end
    core_done = 1'b1; step; core_done = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL drain_done: got %b exp 1", done); end
  endtask

  task automatic test_reset_mid_feed;
    start_run;
    core_out_valid = 1'b1; core_out_addr = 4'd2; core_out_data = 16'h0005; step;
    core_out_valid = 1'b0; step;
    checks++; if (out_count !== 4'd1 || busy !== 1'b1) begin errors++;
      $display("FAIL rstmid_pre: got cnt=%0d busy=%b exp 1 1", out_count, busy); end
    reset = 1'b1; step;
    checks++; if ({busy, done, error, img_rd_en, core_enable, core_in_valid, res_wr_en} !== 7'b0) begin errors++;
      $display("FAIL rstmid_flags: got %b exp 0000000", {busy, done, error, img_rd_en, core_enable, core_in_valid, res_wr_en}); end
    checks++; if (cycle_count !== 32'd0 || out_count !== 4'd0) begin errors++;
      $display("FAIL rstmid_counts: got cyc=%0d cnt=%0d exp 0 0", cycle_count, out_count); end
    checks++; if (img_rd_addr !== 4'd0 || core_in_data !== 16'd0 || res_wr_addr !== 3'd0 || res_wr_data !== 16'd0) begin errors++;
      $display("FAIL rstmid_buses: got ra=%0d cd=%0d wa=%0d wd=%0d exp 0", img_rd_addr, core_in_data, res_wr_addr, res_wr_data); end
    reset = 1'b0; step;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got %b exp 0", busy); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stalls;
    test_early_done;
    test_timeout;
    test_bad_addr_abort;
    test_start_in_drain;
    test_reset_mid_feed;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
